pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/pipe_hazard_unit.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: forwarding select encoding, stage indices and per-stage shadow flags for pipeline_ctrl
package riscv_pipe_pkg;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
   } stage_info_t;
endpackage

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: combinational load-use/MEM-stage hazard detection and EX operand forwarding selects
//   info, rd            : shadow flags and destination of stages EX..WB
//   id_*                : ID-stage sources and valid; raise hazard when ID must wait
//   ex_*                : EX-stage sources captured at ID->EX; drive fwd_a_sel/fwd_b_sel
module pipe_hazard_unit
   import riscv_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int REG_ADDR_W = 5
) (
   input  stage_info_t [NUM_STAGES-1:STG_EX]          info,
   input  logic [NUM_STAGES-1:STG_EX][REG_ADDR_W-1:0] rd,
   input  logic                                       id_valid,
   input  logic [REG_ADDR_W-1:0]                      id_rs1,
   input  logic [REG_ADDR_W-1:0]                      id_rs2,
   input  logic                                       id_rs1_used,
   input  logic                                       id_rs2_used,
   input  logic [REG_ADDR_W-1:0]                      ex_rs1,
   input  logic [REG_ADDR_W-1:0]                      ex_rs2,
   input  logic                                       ex_rs1_used,
   input  logic                                       ex_rs2_used,
   output logic                                       hazard,
   output fwd_sel_e                                   fwd_a_sel,
   output fwd_sel_e                                   fwd_b_sel
);
   // x0 is hard-wired zero, so it never produces a dependency
   function automatic logic hit(input logic [REG_ADDR_W-1:0] src, input logic used, input int k);
      return used && src != '0 && info[k].valid && info[k].reg_write && rd[k] == src;
   endfunction
   // a load in stage 3 has no data yet, so it must not be forwarded
   function automatic fwd_sel_e pick(input logic [REG_ADDR_W-1:0] src, input logic used);
      return (hit(src, used, STG_MEM) && !info[STG_MEM].mem_read) ? FWD_MEM :
             hit(src, used, NUM_STAGES-1) ? FWD_WB : FWD_RF;
   endfunction
   // stages 3..N-3 have no forwarding path; a load in EX is not ready either
   always_comb begin
      hazard = 1'b0;
      for (int k = STG_EX; k < NUM_STAGES; k++)
         if (k <= NUM_STAGES-3 && (info[k].mem_read || k >= STG_MEM) &&
             (hit(id_rs1, id_rs1_used, k) || hit(id_rs2, id_rs2_used, k)))
            hazard = id_valid;
      fwd_a_sel = pick(ex_rs1, ex_rs1_used);
      fwd_b_sel = pick(ex_rs2, ex_rs2_used);
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: in-order pipeline control (stall, flush, bubble, forwarding, retire, perf counters)
//   clk, rst (sync, active-low)
//   if_valid, id_rs1/rs2(+_used), id_rd, id_reg_write, id_mem_read : IF/ID inputs
//   ex_branch_taken, mem_busy : EX branch resolution and data-memory freeze
//   stall_if, stall_id, flush_front, bubble_ex, fwd_a_sel, fwd_b_sel, stage_valid, retire : control
//   retire_cnt, stall_cnt : counters, live only when PIPE_PERF_CNT_EN is defined, else tied 0
module pipeline_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  mem_busy,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  flush_front,
   output logic                  bubble_ex,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic                  retire,
   output logic [31:0]           retire_cnt,
   output logic [31:0]           stall_cnt
);
   logic [1:0]                                 front_q, front_d;
   stage_info_t [NUM_STAGES-1:STG_EX]          info_q, info_d;
   logic [NUM_STAGES-1:STG_EX][REG_ADDR_W-1:0] rd_q, rd_d;
   logic [REG_ADDR_W-1:0]                      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic                                       ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
   logic                                       hazard, branch;
   fwd_sel_e                                   fwd_a, fwd_b;

   pipe_hazard_unit #(.NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .info(info_q), .rd(rd_q), .id_valid(front_q[1]),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rs1(ex_rs1_q), .ex_rs2(ex_rs2_q), .ex_rs1_used(ex_rs1_used_q), .ex_rs2_used(ex_rs2_used_q),
      .hazard(hazard), .fwd_a_sel(fwd_a), .fwd_b_sel(fwd_b)
   );

   assign branch = ex_branch_taken & info_q[STG_EX].valid;

   always_comb begin
      front_d       = front_q;
      info_d        = info_q;
      rd_d          = rd_q;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_rs1_used_d = ex_rs1_used_q;
      ex_rs2_used_d = ex_rs2_used_q;
      if (!mem_busy) begin
         for (int k = STG_MEM; k < NUM_STAGES; k++) begin
            info_d[k] = info_q[k-1];
            rd_d[k]   = rd_q[k-1];
         end
         // branch squashes IF/ID/EX; hazard holds IF/ID and bubbles EX
         front_d              = branch ? 2'b00 : hazard ? front_q : {front_q[0], if_valid};
         info_d[STG_EX]       = (branch || hazard) ? '0 :
                                '{front_q[1], id_reg_write & front_q[1], id_mem_read & front_q[1]};
         rd_d[STG_EX]         = (branch || hazard || !front_q[1]) ? '0 : id_rd;
         ex_rs1_d             = id_rs1;
         ex_rs2_d             = id_rs2;
         ex_rs1_used_d        = id_rs1_used & front_q[1] & ~branch & ~hazard;
         ex_rs2_used_d        = id_rs2_used & front_q[1] & ~branch & ~hazard;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         front_q       <= '0;
         info_q        <= '0;
         rd_q          <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rs1_used_q <= 1'b0;
         ex_rs2_used_q <= 1'b0;
      end else begin
         front_q       <= front_d;
         info_q        <= info_d;
         rd_q          <= rd_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rs1_used_q <= ex_rs1_used_d;
         ex_rs2_used_q <= ex_rs2_used_d;
      end
   end

   always_comb begin
      stage_valid                = '0;
      stage_valid[STG_ID:STG_IF] = front_q;
      for (int k = STG_EX; k < NUM_STAGES; k++)
         stage_valid[k] = info_q[k].valid;
   end

   assign stall_if    = mem_busy | (hazard & ~branch);
   assign stall_id    = stall_if;
   assign flush_front = ~mem_busy & branch;
   assign bubble_ex   = ~mem_busy & (branch | hazard);
   assign fwd_a_sel   = mem_busy ? FWD_RF : fwd_a;
   assign fwd_b_sel   = mem_busy ? FWD_RF : fwd_b;
   assign retire      = stage_valid[NUM_STAGES-1] & ~mem_busy;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] retire_cnt_q, retire_cnt_d, stall_cnt_q, stall_cnt_d;
   assign retire_cnt_d = retire_cnt_q + 32'(retire);
   assign stall_cnt_d  = stall_cnt_q + 32'(stall_id);
   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end
   assign retire_cnt = retire_cnt_q;
   assign stall_cnt  = stall_cnt_q;
`else
   assign retire_cnt = '0;
   assign stall_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven and directed checks of pipeline_ctrl at depths 5 and 7
module tb_pipeline_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       if_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, ex_branch_taken, mem_busy;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic        sif5, sid5, fl5, bub5, ret5, sif7, sid7, fl7, bub7, ret7;
   logic [1:0]  fa5, fb5, fa7, fb7;
   logic [4:0]  sv5;
   logic [6:0]  sv7;
   logic [31:0] rc5, sc5, rc7, sc7;
   logic [13:0] got5;
   assign got5 = {sif5, sid5, fl5, bub5, fa5, fb5, sv5, ret5};

   pipeline_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5)) u5 (
      .clk(clk), .rst(rst), .if_valid(if_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .stall_if(sif5), .stall_id(sid5), .flush_front(fl5), .bubble_ex(bub5),
      .fwd_a_sel(fa5), .fwd_b_sel(fb5), .stage_valid(sv5), .retire(ret5),
      .retire_cnt(rc5), .stall_cnt(sc5)
   );

   pipeline_ctrl #(.NUM_STAGES(7), .REG_ADDR_W(5)) u7 (
      .clk(clk), .rst(rst), .if_valid(if_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .stall_if(sif7), .stall_id(sid7), .flush_front(fl7), .bubble_ex(bub7),
      .fwd_a_sel(fa7), .fwd_b_sel(fb7), .stage_valid(sv7), .retire(ret7),
      .retire_cnt(rc7), .stall_cnt(sc7)
   );

   typedef struct {
      int          ifv, rs1, rs2, u1, u2, rd, rw, mr;
      logic [13:0] exp;
   } vec_t;
   vec_t tbl[15];

   int n_vec = 0;
   int n_err = 0;
`ifdef PIPE_PERF_CNT_EN
   int perf = 1;
`else
   int perf = 0;
`endif

   function automatic logic [13:0] e(input int s, input int fl, input int bub, input int fa,
                                     input int fb, input int sv, input int ret);
      return {s[0], s[0], fl[0], bub[0], fa[1:0], fb[1:0], sv[4:0], ret[0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic apply(input int ifv, input int rs1, input int rs2, input int u1, input int u2,
                        input int rd, input int rw, input int mr);
      if_valid     = ifv[0];
      id_rs1       = 5'(rs1);
      id_rs2       = 5'(rs2);
      id_rs1_used  = u1[0];
      id_rs2_used  = u2[0];
      id_rd        = 5'(rd);
      id_reg_write = rw[0];
      id_mem_read  = mr[0];
   endtask

   task automatic rst_pulse();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      ex_branch_taken = 1'b0;
      mem_busy        = 1'b0;
      rst             = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      // lw x5; add x6,x5,x1; add x5; sub x7,x5,x5; lw x0; add x6,x0,x0
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 'b00000, 0)};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 'b00001, 0)};
      tbl[2]  = '{0, 0, 0, 0, 0, 5, 1, 1, e(0, 0, 0, 0, 0, 'b00011, 0)};
      tbl[3]  = '{0, 5, 1, 1, 1, 6, 1, 0, e(1, 0, 1, 0, 0, 'b00110, 0)};
      tbl[4]  = '{0, 5, 1, 1, 1, 6, 1, 0, e(0, 0, 0, 0, 0, 'b01010, 0)};
      tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 'b10100, 1)};
      tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 'b01001, 0)};
      tbl[7]  = '{0, 1, 2, 1, 1, 5, 1, 0, e(0, 0, 0, 0, 0, 'b10011, 1)};
      tbl[8]  = '{0, 5, 5, 1, 1, 7, 1, 0, e(0, 0, 0, 0, 0, 'b00110, 0)};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 2, 2, 'b01100, 0)};
      tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 'b11000, 1)};
      tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 'b10001, 1)};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 0, 'b00011, 0)};
      tbl[13] = '{0, 0, 0, 1, 1, 6, 1, 0, e(0, 0, 0, 0, 0, 'b00110, 0)};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 'b01100, 0)};

      rst_pulse();
      @(negedge clk);
      #1;
      chk("reset_u5", {18'd0, got5}, 32'd0);
      chk("reset_u7_sv", {25'd0, sv7}, 32'd0);
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].ifv, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].rw, tbl[i].mr);
         #1;
         chk($sformatf("vec%0d", i), {18'd0, got5}, {18'd0, tbl[i].exp});
         @(negedge clk);
      end
      chk("retire_cnt_tbl", rc5, perf != 0 ? 32'd4 : 32'd0);
      chk("stall_cnt_tbl", sc5, perf != 0 ? 32'd1 : 32'd0);

      // taken branch in EX while ID has a load-use on it
      rst_pulse();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      apply(1, 0, 0, 0, 0, 5, 1, 1);
      @(negedge clk);
      apply(1, 5, 0, 1, 0, 6, 1, 0);
      ex_branch_taken = 1'b1;
      #1;
      chk("br_ctrl", {28'd0, fl5, bub5, sid5, sif5}, 32'b1100);
      @(negedge clk);
      ex_branch_taken = 1'b0;
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("br_sv", {27'd0, sv5}, 32'b01000);
      @(negedge clk);

      // three-cycle memory freeze with WB valid
      mem_busy = 1'b1;
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("busy%0d_sv", j), {27'd0, sv5}, 32'b10000);
         chk($sformatf("busy%0d_out", j), {23'd0, sif5, sid5, fl5, bub5, ret5, fa5, fb5}, 32'b110000000);
         @(negedge clk);
      end
      mem_busy = 1'b0;
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("resume", {26'd0, sv5, ret5}, 32'b100001);
      chk("stall_cnt_busy", sc5, perf != 0 ? 32'd3 : 32'd0);
      @(negedge clk);
      #1;
      chk("resume_drain", {27'd0, sv5}, 32'd0);

      // reset asserted while a load-use stall is pending
      rst_pulse();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 5, 1, 1);
      @(negedge clk);
      apply(0, 5, 0, 1, 0, 6, 1, 0);
      #1;
      chk("pre_rst_stall", {31'd0, sid5}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_out", {18'd0, got5}, 32'd0);
      chk("post_rst_cnt", rc5 | sc5, 32'd0);
      @(negedge clk);
      #1;
      chk("post_rst_nostall", {31'd0, sid5}, 32'd0);

      // depth 7: add x5, gap, use x5 -> held in ID while add sits in stages 3 and 4
      rst_pulse();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      apply(1, 0, 0, 0, 0, 5, 1, 0);
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      apply(0, 5, 0, 1, 0, 6, 1, 0);
      #1;
      chk("n7_stall1", {29'd0, sid7, sif7, bub7}, 32'b111);
      @(negedge clk);
      #1;
      chk("n7_stall2", {29'd0, sid7, sif7, bub7}, 32'b111);
      @(negedge clk);
      #1;
      chk("n7_go", {31'd0, sid7}, 32'd0);
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("n7_fwd", {23'd0, fa7, sv7}, {23'd0, 2'b01, 7'b1000100});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
